img_index: RTL and testbench

- Colour lookup table (palette) for the VGA pixel pipeline.
- Maps an 8-bit colour index, produced by the game/render logic, to a 24-bit RGB word that drives r_data/g_data/b_data.
- Sits between the per-pixel colour_index generator and the output pixel register.
- Synchronous read, one clock of latency, matching the sync-signal delay.

---
 rtl/vga_pkg.sv | 38 +++
 rtl/img_index_rom_lut.sv | 18 +
 rtl/img_index.sv | 75 +++++++
 tb/tb_img_index.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants: index/colour widths, palette role indices and the
// default RGB value of each of the 16 fixed palette entries.
package vga_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 24;

  // Palette role indices, used by the render logic when it picks a colour.
  localparam logic [ADDR_W-1:0] COL_BOUNDARY = 8'd0;
  localparam logic [ADDR_W-1:0] COL_SNAKE1   = 8'd1;
  localparam logic [ADDR_W-1:0] COL_SNAKE2   = 8'd2;
  localparam logic [ADDR_W-1:0] COL_APPLE    = 8'd3;
  localparam logic [ADDR_W-1:0] COL_BG       = 8'd4;
  localparam logic [ADDR_W-1:0] COL_YELLOW   = 8'd5;
  localparam logic [ADDR_W-1:0] COL_CYAN     = 8'd6;
  localparam logic [ADDR_W-1:0] COL_MAGENTA  = 8'd7;
  localparam logic [ADDR_W-1:0] COL_GREY     = 8'd8;
  localparam logic [ADDR_W-1:0] COL_ORANGE   = 8'd9;
  localparam logic [ADDR_W-1:0] COL_DK_GREEN = 8'd10;
  localparam logic [ADDR_W-1:0] COL_NAVY     = 8'd11;
  localparam logic [ADDR_W-1:0] COL_MAROON   = 8'd12;
  localparam logic [ADDR_W-1:0] COL_PURPLE   = 8'd13;
  localparam logic [ADDR_W-1:0] COL_OLIVE    = 8'd14;
  localparam logic [ADDR_W-1:0] COL_TEAL     = 8'd15;

  // Default RGB for entries 0..15, ordered by index.
  localparam logic [DATA_W-1:0] DEFAULT_RGB [16] = '{
    24'h000000, 24'h00FF00, 24'h0000FF, 24'hFF0000,
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'hFF00FF,
    24'h808080, 24'hFF8000, 24'h008000, 24'h000080,
    24'h800000, 24'h800080, 24'h808000, 24'h008080
  };

  function automatic logic [DATA_W-1:0] default_rgb(input logic [3:0] idx);
    return DEFAULT_RGB[idx];
  endfunction

endpackage

// File: rtl/img_index_rom_lut.sv
// Combinational palette lookup: fixed colours for indices 0..15 and a
// greyscale ramp {i,i,i} for indices 16..255. Every index is defined.
module img_index_rom_lut
  import vga_pkg::*;
(
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] rgb
);

  // Fixed colour block below 16, grey ramp above.
  always_comb begin
    rgb = {address, address, address};
    if (address[ADDR_W-1:4] == '0) begin
      rgb = default_rgb(address[3:0]);
    end
  end

endmodule

// File: rtl/img_index.sv
// Registered colour palette for the VGA pixel pipeline: one clock of
// latency from address to q, q cleared asynchronously by reset.
// Optional macro IMG_INDEX_WR_EN makes entries 0..15 writable through
// wren/wraddr/wdata; a read of an entry on the same edge it is written
// returns the old colour.
module img_index
  import vga_pkg::*;
#(
  parameter int ADDR_W_P = vga_pkg::ADDR_W,
  parameter int DATA_W_P = vga_pkg::DATA_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   address,
`ifdef IMG_INDEX_WR_EN
  input  logic                wren,
  input  logic [3:0]          wraddr,
  input  logic [DATA_W-1:0]   wdata,
`endif
  output logic [DATA_W-1:0]   q
);

  // Only the 8-bit index / 24-bit colour configuration exists.
  generate
    if (ADDR_W_P != 8 || DATA_W_P != 24) begin : g_bad_param
      $error("img_index supports only ADDR_W=8 and DATA_W=24");
    end
  endgenerate

  logic [DATA_W-1:0] lut_rgb;
  logic [DATA_W-1:0] rd_data;

  img_index_rom_lut u_lut (
    .address (address),
    .rgb     (lut_rgb)
  );

`ifdef IMG_INDEX_WR_EN
  logic [DATA_W-1:0] pal_q [16];

  // Override register file for entries 0..15, reset to the default colours.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        pal_q[i] <= default_rgb(4'(i));
      end
    end else if (wren) begin
      pal_q[wraddr] <= wdata;
    end
  end

  // Low entries come from the registers (pre-write value), the rest from the ramp.
  always_comb begin
    rd_data = lut_rgb;
    if (address[ADDR_W-1:4] == '0) begin
      rd_data = pal_q[address[3:0]];
    end
  end
`else
  // Without overrides the lookup table is the whole palette.
  always_comb begin
    rd_data = lut_rgb;
  end
`endif

  // Output pixel register; reset forces black immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else begin
      q <= rd_data;
    end
  end

endmodule

// File: tb/tb_img_index.sv
// Testbench for img_index: reset behaviour, fixed table, grey ramp,
// back-to-back reads, randomized reads against a palette model, and the
// writable-entry sequences when IMG_INDEX_WR_EN is defined.
module tb_img_index;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  address = 8'd0;
  logic [23:0] q;
`ifdef IMG_INDEX_WR_EN
  logic        wren = 1'b0;
  logic [3:0]  wraddr = 4'd0;
  logic [23:0] wdata = 24'd0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [23:0] ref_pal [256];
  logic [23:0] exp_q [$];

  typedef struct {
    logic [7:0]  addr;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs [19];

  img_index dut (
    .clock   (clock),
    .reset   (reset),
    .address (address),
`ifdef IMG_INDEX_WR_EN
    .wren    (wren),
    .wraddr  (wraddr),
    .wdata   (wdata),
`endif
    .q       (q)
  );

  // Clock / reset block
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: q=%06h expected=%06h at %0t", name, got, exp, $time);
    end
  endtask

  // Driver: present an address just after an edge, return just after the next edge.
  task automatic step(input logic [7:0] a);
    address = a;
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    #2;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Behavioural palette model: literal colours, then a grey ramp.
  task automatic model_reset();
    logic [23:0] fixed_tbl [16];
    logic [7:0]  b;
    fixed_tbl = '{24'h000000, 24'h00FF00, 24'h0000FF, 24'hFF0000,
                  24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'hFF00FF,
                  24'h808080, 24'hFF8000, 24'h008000, 24'h000080,
                  24'h800000, 24'h800080, 24'h808000, 24'h008080};
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      ref_pal[i] = (i < 16) ? fixed_tbl[i] : {b, b, b};
    end
  endtask

  initial begin
    vecs[0]  = '{8'd0,   24'h000000};
    vecs[1]  = '{8'd1,   24'h00FF00};
    vecs[2]  = '{8'd2,   24'h0000FF};
    vecs[3]  = '{8'd3,   24'hFF0000};
    vecs[4]  = '{8'd4,   24'hFFFFFF};
    vecs[5]  = '{8'd5,   24'hFFFF00};
    vecs[6]  = '{8'd6,   24'h00FFFF};
    vecs[7]  = '{8'd7,   24'hFF00FF};
    vecs[8]  = '{8'd8,   24'h808080};
    vecs[9]  = '{8'd9,   24'hFF8000};
    vecs[10] = '{8'd10,  24'h008000};
    vecs[11] = '{8'd11,  24'h000080};
    vecs[12] = '{8'd12,  24'h800000};
    vecs[13] = '{8'd13,  24'h800080};
    vecs[14] = '{8'd14,  24'h808000};
    vecs[15] = '{8'd15,  24'h008080};
    vecs[16] = '{8'd16,  24'h101010};
    vecs[17] = '{8'd128, 24'h808080};
    vecs[18] = '{8'd255, 24'hFFFFFF};

    model_reset();

    // Power-up reset: q black before any clock edge.
    #1 reset = 1'b1;
    #1 check("reset_async", q, 24'h000000);
    @(posedge clock);
    #1 check("reset_held", q, 24'h000000);
    reset = 1'b0;

    // First read after release.
    step(8'd4);
    check("first_after_reset", q, 24'hFFFFFF);

    // Table sweep, back-to-back, one cycle latency.
    for (int i = 0; i < 19; i++) begin
      step(vecs[i].addr);
      check($sformatf("table_%0d", vecs[i].addr), q, vecs[i].exp);
    end

    // Alternating addresses every cycle.
    for (int i = 0; i < 4; i++) begin
      step((i % 2 == 0) ? 8'd1 : 8'd2);
      check($sformatf("alt_%0d", i), q, (i % 2 == 0) ? 24'h00FF00 : 24'h0000FF);
    end

    // Mid-cycle reset with a colour on q.
    step(8'd3);
    check("pre_midreset", q, 24'hFF0000);
    #3 reset = 1'b1;
    #1 check("midreset_immediate", q, 24'h000000);
    @(posedge clock);
    #1 check("midreset_held", q, 24'h000000);
    reset = 1'b0;
    step(8'd4);
    check("midreset_release", q, 24'hFFFFFF);

`ifdef IMG_INDEX_WR_EN
    // Same-edge write and read of entry 3 returns the old colour.
    address = 8'd3; wren = 1'b1; wraddr = 4'd3; wdata = 24'h123456;
    @(posedge clock);
    #1 wren = 1'b0;
    check("wr_same_edge_old", q, 24'hFF0000);
    step(8'd3);
    check("wr_new_value", q, 24'h123456);
    pulse_reset();
    step(8'd3);
    check("wr_reset_default", q, 24'hFF0000);

    // Write entry 0, read it, ramp unaffected.
    address = 8'd5; wren = 1'b1; wraddr = 4'd0; wdata = 24'hABCDEF;
    @(posedge clock);
    #1 wren = 1'b0;
    check("wr_other_read", q, 24'hFFFF00);
    step(8'd0);
    check("wr_entry0", q, 24'hABCDEF);
    step(8'd16);
    check("wr_ramp_untouched", q, 24'h101010);
`endif

    // Randomized reads (and writes, when available) against the model.
    pulse_reset();
    model_reset();
    for (int i = 0; i < 300; i++) begin
      address = 8'($urandom_range(0, 255));
      exp_q.push_back(ref_pal[address]);
`ifdef IMG_INDEX_WR_EN
      wren   = ($urandom_range(0, 3) == 0);
      wraddr = 4'($urandom_range(0, 15));
      wdata  = 24'($urandom);
      if (wren) ref_pal[wraddr] = wdata;
`endif
      @(posedge clock);
      #1;
      check($sformatf("rand_%0d", i), q, exp_q.pop_front());
    end
`ifdef IMG_INDEX_WR_EN
    wren = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
